mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter_starve_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
// Owner tag routes returning read data; widths match the single-port SRAM macro.
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_IM = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int SRAM_AW = 14;
    localparam int SRAM_DW = 32;

    localparam logic [SRAM_DW-1:0] BWEB_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes, SRAM pins and the stall flag around mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus SRAM model.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic               im_req;
    logic [15:0]        im_addr;
    logic               im_gnt;
    logic               im_rvalid;
    logic [SRAM_DW-1:0] im_rdata;

    logic               dm_req;
    logic               dm_we;
    logic [15:0]        dm_addr;
    logic [SRAM_DW-1:0] dm_wdata;
    logic [SRAM_DW-1:0] dm_bweb;
    logic               dm_gnt;
    logic               dm_rvalid;
    logic [SRAM_DW-1:0] dm_rdata;

    logic               sram_ceb;
    logic               sram_web;
    logic [SRAM_AW-1:0] sram_a;
    logic [SRAM_DW-1:0] sram_d;
    logic [SRAM_DW-1:0] sram_bweb;
    logic [SRAM_DW-1:0] sram_q;

    logic               stall;

    modport slave (
        input  im_req, im_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
        input  sram_q,
        output im_gnt, im_rvalid, im_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output sram_ceb, sram_web, sram_a, sram_d, sram_bweb,
        output stall
    );

    modport master (
        output im_req, im_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
        output sram_q,
        input  im_gnt, im_rvalid, im_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  sram_ceb, sram_web, sram_a, sram_d, sram_bweb,
        input  stall
    );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive IM denials; clear wins over increment.
// at_limit tells the arbiter to hand the next contested cycle to IM.
module starve_counter #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) onto one single-port SRAM.
// DM normally wins; IM is forced through after STARVE_LIMIT consecutive denials.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    import mem_arbiter_pkg::*;

    logic   gnt_im;
    logic   gnt_dm;
    logic   starved;
    logic   dm_store;
    logic   rd_issue;
    logic   rd_pending;
    owner_e rd_owner;
    logic   im_rv;
    logic   dm_rv;
    logic   unused_addr_hi;

    assign unused_addr_hi = ^{bus.im_addr[15:14], bus.dm_addr[15:14]};

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.im_req & ~gnt_im),
        .clr      (gnt_im),
        .at_limit (starved)
    );

    // Grant decision: combinational from this cycle's requests and the starve state.
    always_comb begin
        gnt_im = 1'b0;
        gnt_dm = 1'b0;
        if (!rst) begin
            if (bus.dm_req && !(bus.im_req && starved)) begin
                gnt_dm = 1'b1;
            end else if (bus.im_req) begin
                gnt_im = 1'b1;
            end
        end
    end

    assign dm_store = gnt_dm & bus.dm_we;
    assign rd_issue = gnt_im | (gnt_dm & ~bus.dm_we);

    always_comb begin
        bus.sram_ceb  = 1'b1;
        bus.sram_web  = 1'b1;
        bus.sram_a    = '0;
        bus.sram_d    = '0;
        bus.sram_bweb = BWEB_NONE;
        if (gnt_im || gnt_dm) begin
            bus.sram_ceb = 1'b0;
            bus.sram_web = ~dm_store;
            bus.sram_a   = gnt_dm ? bus.dm_addr[SRAM_AW-1:0] : bus.im_addr[SRAM_AW-1:0];
            bus.sram_d   = bus.dm_wdata;
            if (dm_store) begin
                bus.sram_bweb = bus.dm_bweb;
            end
        end
    end

    assign bus.im_gnt = gnt_im;
    assign bus.dm_gnt = gnt_dm;
    assign bus.stall  = (bus.im_req & ~gnt_im) | (bus.dm_req & ~gnt_dm);

    // Read return stage: owner tag follows the SRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
        end
        rd_owner <= gnt_dm ? OWN_DM : OWN_IM;
    end

    // Gating with rst keeps a read issued just before reset from surfacing.
    assign im_rv = rd_pending & ~rst & (rd_owner == OWN_IM);
    assign dm_rv = rd_pending & ~rst & (rd_owner == OWN_DM);

    assign bus.im_rvalid = im_rv;
    assign bus.dm_rvalid = dm_rv;
    assign bus.im_rdata  = im_rv ? bus.sram_q : '0;
    assign bus.dm_rdata  = dm_rv ? bus.sram_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: an SRAM model, a per-cycle reference model compared on
// every falling edge, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [16384];
    logic [31:0] shadow [16384];
    logic [31:0] q_r;

    assign bus.sram_q = q_r;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [31:0] bweb);
        return (old_v & bweb) | (d & ~bweb);
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // SRAM behaviour: write in the enabled cycle, read data the following cycle.
    always @(posedge clk) begin
        if (bus.sram_ceb === 1'b0) begin
            if (bus.sram_web === 1'b0)
                mem[bus.sram_a] <= merge(mem[bus.sram_a], bus.sram_d, bus.sram_bweb);
            else
                q_r <= mem[bus.sram_a];
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_starve = 0;
    bit          m_pend   = 1'b0;
    bit          m_pend_dm;
    logic [31:0] m_pend_data;
    bit          eg_im, eg_dm, e_any, e_store;
    logic [13:0] e_a;
    logic [31:0] e_d, e_bweb, e_imrd, e_dmrd;
    bit          e_imrv, e_dmrv;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                eg_im = 1'b0;
                eg_dm = 1'b0;
            end else begin
                eg_dm = bus.dm_req && !(bus.im_req && (m_starve == LIMIT));
                eg_im = bus.im_req && !eg_dm;
            end
            e_any   = eg_im || eg_dm;
            e_store = eg_dm && bus.dm_we;
            e_a     = !e_any ? 14'd0 : (eg_dm ? bus.dm_addr[13:0] : bus.im_addr[13:0]);
            e_d     = e_any ? bus.dm_wdata : 32'd0;
            e_bweb  = e_store ? bus.dm_bweb : 32'hFFFF_FFFF;
            e_imrv  = !rst && m_pend && !m_pend_dm;
            e_dmrv  = !rst && m_pend && m_pend_dm;
            e_imrd  = e_imrv ? m_pend_data : 32'd0;
            e_dmrd  = e_dmrv ? m_pend_data : 32'd0;

            cmp("m_im_gnt",    32'(bus.im_gnt),    32'(eg_im));
            cmp("m_dm_gnt",    32'(bus.dm_gnt),    32'(eg_dm));
            cmp("m_stall",     32'(bus.stall),
                32'((bus.im_req && !eg_im) || (bus.dm_req && !eg_dm)));
            cmp("m_sram_ceb",  32'(bus.sram_ceb),  32'(!e_any));
            cmp("m_sram_web",  32'(bus.sram_web),  32'(!e_store));
            cmp("m_sram_a",    32'(bus.sram_a),    32'(e_a));
            cmp("m_sram_d",    bus.sram_d,         e_d);
            cmp("m_sram_bweb", bus.sram_bweb,      e_bweb);
            cmp("m_im_rvalid", 32'(bus.im_rvalid), 32'(e_imrv));
            cmp("m_dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dmrv));
            cmp("m_im_rdata",  bus.im_rdata,       e_imrd);
            cmp("m_dm_rdata",  bus.dm_rdata,       e_dmrd);

            if (rst) begin
                m_starve = 0;
                m_pend   = 1'b0;
            end else begin
                m_pend      = eg_im || (eg_dm && !bus.dm_we);
                m_pend_dm   = eg_dm;
                m_pend_data = shadow[e_a];
                if (e_store)
                    shadow[e_a] = merge(shadow[e_a], bus.dm_wdata, bus.dm_bweb);
                if (eg_im)
                    m_starve = 0;
                else if (bus.im_req && m_starve < LIMIT)
                    m_starve = m_starve + 1;
            end
        end
    end

    task automatic idle();
        bus.im_req   = 1'b0;
        bus.im_addr  = 16'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 16'h0;
        bus.dm_wdata = 32'h0;
        bus.dm_bweb  = 32'hFFFF_FFFF;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        mem[16'h0010] = 32'hDEAD_BEEF; shadow[16'h0010] = 32'hDEAD_BEEF;
        mem[4]        = 32'h1122_3344; shadow[4]        = 32'h1122_3344;
        mem[1]        = 32'h0101_0101; shadow[1]        = 32'h0101_0101;
        mem[2]        = 32'h0202_0202; shadow[2]        = 32'h0202_0202;
        chk_en = 1'b1;

        // Reset with both requests pending: nothing granted, SRAM idle
        bus.im_req = 1'b1;
        bus.dm_req = 1'b1;
        @(negedge clk);
        cmp("rst_im_gnt", 32'(bus.im_gnt), 32'd0);
        cmp("rst_dm_gnt", 32'(bus.dm_gnt), 32'd0);
        cmp("rst_ceb",    32'(bus.sram_ceb), 32'd1);
        cmp("rst_bweb",   bus.sram_bweb, 32'hFFFF_FFFF);
        next();

        // IM-only read
        rst = 1'b0;
        idle();
        bus.im_req  = 1'b1;
        bus.im_addr = 16'h0010;
        @(negedge clk);
        cmp("im_rd_gnt", 32'(bus.im_gnt), 32'd1);
        cmp("im_rd_a",   32'(bus.sram_a), 32'h10);
        cmp("im_rd_ceb", 32'(bus.sram_ceb), 32'd0);
        next();
        idle();
        @(negedge clk);
        cmp("im_rd_rvalid", 32'(bus.im_rvalid), 32'd1);
        cmp("im_rd_rdata",  bus.im_rdata, 32'hDEAD_BEEF);
        cmp("im_rd_dm_rdata", bus.dm_rdata, 32'd0);
        next();

        // DM store then load of the same word
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0004;
        bus.dm_wdata = 32'h00AB_0000;
        bus.dm_bweb  = 32'hFF00_FFFF;
        @(negedge clk);
        cmp("st_web",  32'(bus.sram_web), 32'd0);
        cmp("st_bweb", bus.sram_bweb, 32'hFF00_FFFF);
        cmp("st_gnt",  32'(bus.dm_gnt), 32'd1);
        next();
        bus.dm_we   = 1'b0;
        bus.dm_bweb = 32'hFFFF_FFFF;
        @(negedge clk);
        cmp("st_no_rvalid", 32'(bus.dm_rvalid), 32'd0);
        cmp("ld_web",       32'(bus.sram_web), 32'd1);
        next();
        idle();
        @(negedge clk);
        cmp("raw_rvalid", 32'(bus.dm_rvalid), 32'd1);
        cmp("raw_rdata",  bus.dm_rdata, 32'h11AB_3344);
        next();

        // Conflict held five cycles: DM, DM, DM, IM (forced), DM
        bus.im_req  = 1'b1;
        bus.im_addr = 16'h0020;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 16'h0030;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp($sformatf("cf_dm_gnt%0d", c), 32'(bus.dm_gnt), (c == 3) ? 32'd0 : 32'd1);
            cmp($sformatf("cf_im_gnt%0d", c), 32'(bus.im_gnt), (c == 3) ? 32'd1 : 32'd0);
            if (c <= 3)
                cmp($sformatf("cf_stall%0d", c), 32'(bus.stall), 32'd1);
            next();
        end
        idle();
        next();

        // Back-to-back reads: DM @1 then IM @2
        bus.dm_req  = 1'b1;
        bus.dm_addr = 16'h0001;
        next();
        idle();
        bus.im_req  = 1'b1;
        bus.im_addr = 16'h0002;
        @(negedge clk);
        cmp("b2b_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
        cmp("b2b_dm_rdata",  bus.dm_rdata, 32'h0101_0101);
        cmp("b2b_im_gnt",    32'(bus.im_gnt), 32'd1);
        next();
        idle();
        @(negedge clk);
        cmp("b2b_im_rvalid", 32'(bus.im_rvalid), 32'd1);
        cmp("b2b_im_rdata",  bus.im_rdata, 32'h0202_0202);
        cmp("b2b_dm_rvalid2", 32'(bus.dm_rvalid), 32'd0);
        next();

        // DM load granted, reset the following cycle: no data ever returns
        bus.dm_req  = 1'b1;
        bus.dm_addr = 16'h0003;
        @(negedge clk);
        cmp("rl_gnt", 32'(bus.dm_gnt), 32'd1);
        next();
        rst = 1'b1;
        @(negedge clk);
        cmp("rl_rst_rvalid", 32'(bus.dm_rvalid), 32'd0);
        cmp("rl_rst_ceb",    32'(bus.sram_ceb), 32'd1);
        cmp("rl_rst_web",    32'(bus.sram_web), 32'd1);
        cmp("rl_rst_gnt",    32'(bus.dm_gnt), 32'd0);
        next();
        rst = 1'b0;
        idle();
        @(negedge clk);
        cmp("rl_post_rvalid", 32'(bus.dm_rvalid), 32'd0);
        cmp("rl_post_im_rvalid", 32'(bus.im_rvalid), 32'd0);
        next();

        // Mixed traffic on a few addresses, upper address bits toggled, occasional reset
        for (int k = 0; k < 200; k++) begin
            rst          = ($urandom_range(0, 39) == 0);
            bus.im_req   = 1'($urandom_range(0, 1));
            bus.im_addr  = 16'($urandom) & 16'hC007;
            bus.dm_req   = 1'($urandom_range(0, 1));
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = 16'($urandom) & 16'hC007;
            bus.dm_wdata = $urandom;
            bus.dm_bweb  = $urandom;
            next();
        end
        rst = 1'b0;
        idle();
        repeat (3) next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
